// File: rtl/l2_mem_pkg.sv
// Shared types, widths and ROM-region line bounds for the L2 memory router.
// The line address is the byte address with the 64-byte line offset removed.
package l2_mem_pkg;

  localparam int unsigned TNUM    = 18;
  localparam int unsigned INUM    = 8;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned LADDR_W = TNUM + INUM;

  localparam logic [31:0] ROM_START_ADDR_DEF = 32'h10094;
  localparam logic [31:0] ROM_END_ADDR_DEF   = 32'h11FD8;

  typedef logic [TNUM-1:0]    tag_t;
  typedef logic [INUM-1:0]    index_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [LADDR_W-1:0] laddr_t;

  localparam laddr_t ROM_LINE_LO = ROM_START_ADDR_DEF[31:6];
  localparam laddr_t ROM_LINE_HI = ROM_END_ADDR_DEF[31:6];

  typedef enum logic [2:0] {
    IDLE,
    WB,
    WB_DROP,
    RD_ROM,
    RD_DDR,
    RESP,
    GUARD
  } state_t;

endpackage

// File: rtl/l2_mem_router_if.sv
// Bundle of the L2 miss port and both backend ports of the memory router.
// master is the environment side (L2 + backends), slave is the router.
interface l2_mem_router_if;
  import l2_mem_pkg::*;

  logic   read_L2_MEM;
  logic   write_L2_MEM;
  tag_t   tag_L2_MEM;
  index_t index_L2_MEM;
  tag_t   write_tag_L2_MEM;
  line_t  write_data_L2_MEM;
  line_t  read_data_MEM_L2;
  logic   ready_MEM_L2;

  logic   rom_read;
  tag_t   rom_tag;
  index_t rom_index;
  logic   rom_ready;
  line_t  rom_data;

  logic   ddr_read;
  logic   ddr_write;
  tag_t   ddr_tag;
  tag_t   ddr_write_tag;
  index_t ddr_index;
  line_t  ddr_write_data;
  logic   ddr_ready;
  line_t  ddr_data;

  logic   busy;
  logic   err;

  modport master (
    output read_L2_MEM, write_L2_MEM, tag_L2_MEM, index_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
           rom_ready, rom_data, ddr_ready, ddr_data,
    input  read_data_MEM_L2, ready_MEM_L2,
           rom_read, rom_tag, rom_index,
           ddr_read, ddr_write, ddr_tag, ddr_write_tag, ddr_index, ddr_write_data,
           busy, err
  );

  modport slave (
    input  read_L2_MEM, write_L2_MEM, tag_L2_MEM, index_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
           rom_ready, rom_data, ddr_ready, ddr_data,
    output read_data_MEM_L2, ready_MEM_L2,
           rom_read, rom_tag, rom_index,
           ddr_read, ddr_write, ddr_tag, ddr_write_tag, ddr_index, ddr_write_data,
           busy, err
  );

endinterface

// File: rtl/l2_mem_region_decode.sv
// Combinational classifier: does line address {tag, index} fall in the ROM region?
module l2_mem_region_decode
  import l2_mem_pkg::*;
#(
  parameter laddr_t LINE_LO = ROM_LINE_LO,
  parameter laddr_t LINE_HI = ROM_LINE_HI
) (
  input  tag_t   tag,
  input  index_t index,
  output logic   is_rom
);

  laddr_t line;

  always_comb begin
    line   = {tag, index};
    is_rom = (line >= LINE_LO) && (line <= LINE_HI);
  end

endmodule

// File: rtl/l2_mem_router.sv
// Sequences L2-miss transactions: optional DDR writeback, then a refill read from
// the instruction ROM or DDR, returning one registered line with a one-cycle ready.
module l2_mem_router
  import l2_mem_pkg::*;
#(
  parameter logic [31:0] ROM_START_ADDR = ROM_START_ADDR_DEF,
  parameter logic [31:0] ROM_END_ADDR   = ROM_END_ADDR_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic            clk,
  input logic            rstn,
  l2_mem_router_if.slave bus
);

  localparam laddr_t      LINE_LO  = ROM_START_ADDR[31:6];
  localparam laddr_t      LINE_HI  = ROM_END_ADDR[31:6];
  localparam int unsigned CW       = $clog2(TIMEOUT_CYCLES);
  // Decided one cycle early so the request is already low when the count reaches TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t state_q, state_d;

  tag_t    tag_q, wtag_q, dec_tag, dec_wtag;
  index_t  index_q, dec_index;
  line_t   wdata_q, rdata_q, rdata_d;
  logic    rd_q, wr_q;
  logic    rd_is_rom, wr_is_rom;
  logic    timeout, cnt_last, counting;
  logic [CW-1:0] cnt_q, cnt_d;
  logic    rom_read_q, ddr_read_q, ddr_write_q, ready_q, busy_q, err_q;
  logic    rom_read_d, ddr_read_d, ddr_write_d, ready_d, busy_d, err_d;
  state_t  read_target;

  // In IDLE the live inputs are classified; afterwards only the latched copy matters.
  always_comb begin
    if (state_q == IDLE) begin
      dec_tag   = bus.tag_L2_MEM;
      dec_wtag  = bus.write_tag_L2_MEM;
      dec_index = bus.index_L2_MEM;
    end else begin
      dec_tag   = tag_q;
      dec_wtag  = wtag_q;
      dec_index = index_q;
    end
  end

  l2_mem_region_decode #(.LINE_LO(LINE_LO), .LINE_HI(LINE_HI)) u_rd_decode (
    .tag(dec_tag), .index(dec_index), .is_rom(rd_is_rom)
  );

  l2_mem_region_decode #(.LINE_LO(LINE_LO), .LINE_HI(LINE_HI)) u_wr_decode (
    .tag(dec_wtag), .index(dec_index), .is_rom(wr_is_rom)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout     = 1'b0;
    cnt_last    = (cnt_q == CNT_LAST);
    read_target = rd_is_rom ? RD_ROM : RD_DDR;
    unique case (state_q)
      IDLE: begin
        if (bus.write_L2_MEM)     state_d = wr_is_rom ? WB_DROP : WB;
        else if (bus.read_L2_MEM) state_d = read_target;
      end
      WB: begin
        if (bus.ddr_ready)  state_d = rd_q ? read_target : RESP;
        else if (cnt_last) begin
          state_d = RESP;
          timeout = 1'b1;
        end
      end
      WB_DROP: state_d = rd_q ? read_target : RESP;
      RD_ROM: begin
        if (bus.rom_ready) state_d = RESP;
        else if (cnt_last) begin
          state_d = RESP;
          timeout = 1'b1;
        end
      end
      RD_DDR: begin
        if (bus.ddr_ready) state_d = RESP;
        else if (cnt_last) begin
          state_d = RESP;
          timeout = 1'b1;
        end
      end
      RESP:    state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_read_d  = (state_d == RD_ROM);
    ddr_read_d  = (state_d == RD_DDR);
    ddr_write_d = (state_d == WB);
    ready_d     = (state_d == RESP);
    busy_d      = (state_d != IDLE);
    err_d       = err_q | timeout | (state_d == WB_DROP);
    counting    = (state_q == WB) || (state_q == RD_ROM) || (state_q == RD_DDR);

    rdata_d = rdata_q;
    if ((state_q == RD_ROM) && bus.rom_ready)                      rdata_d = bus.rom_data;
    else if ((state_q == RD_DDR) && bus.ddr_ready)                 rdata_d = bus.ddr_data;
    else if (timeout && ((state_q == RD_ROM) || (state_q == RD_DDR))) rdata_d = '0;

    if (state_d != state_q)                cnt_d = '0;
    else if (counting && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q       <= '0;
      wtag_q      <= '0;
      index_q     <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      rom_read_q  <= 1'b0;
      ddr_read_q  <= 1'b0;
      ddr_write_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (bus.read_L2_MEM || bus.write_L2_MEM)) begin
        tag_q   <= bus.tag_L2_MEM;
        wtag_q  <= bus.write_tag_L2_MEM;
        index_q <= bus.index_L2_MEM;
        wdata_q <= bus.write_data_L2_MEM;
        rd_q    <= bus.read_L2_MEM;
        wr_q    <= bus.write_L2_MEM;
      end
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      rom_read_q  <= rom_read_d;
      ddr_read_q  <= ddr_read_d;
      ddr_write_q <= ddr_write_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  logic unused_wr;
  assign unused_wr = wr_q;

  assign bus.read_data_MEM_L2 = rdata_q;
  assign bus.ready_MEM_L2     = ready_q;
  assign bus.rom_read         = rom_read_q;
  assign bus.rom_tag          = tag_q;
  assign bus.rom_index        = index_q;
  assign bus.ddr_read         = ddr_read_q;
  assign bus.ddr_write        = ddr_write_q;
  assign bus.ddr_tag          = tag_q;
  assign bus.ddr_write_tag    = wtag_q;
  assign bus.ddr_index        = index_q;
  assign bus.ddr_write_data   = wdata_q;
  assign bus.busy             = busy_q;
  assign bus.err              = err_q;

endmodule

// File: tb/tb_l2_mem_router.sv
// Directed bench for l2_mem_router: stimulus pushes expected responses, a
// negedge monitor pops them on every ready_MEM_L2 and tracks backend activity.
module tb_l2_mem_router;
  import l2_mem_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  l2_mem_router_if bus ();

  l2_mem_router #(
    .ROM_START_ADDR(32'h10094),
    .ROM_END_ADDR  (32'h11FD8),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    line_t data;
    logic  err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   rom_cnt = 0, ddr_rd_cnt = 0, ddr_wr_cnt = 0, overlap = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input line_t act, input line_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.rom_read)  rom_cnt++;
      if (bus.ddr_read)  ddr_rd_cnt++;
      if (bus.ddr_write) ddr_wr_cnt++;
      if (bus.ddr_read && bus.ddr_write) overlap++;
      if (bus.ready_MEM_L2) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready: got ready_MEM_L2=1 expected no pending response");
        end else begin
          e = sb.pop_front();
          chk_line("resp_data", bus.read_data_MEM_L2, e.data);
          chk("resp_err", 64'(bus.err), 64'(e.err));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.read_L2_MEM       = 1'b0;
    bus.write_L2_MEM      = 1'b0;
    bus.tag_L2_MEM        = '0;
    bus.index_L2_MEM      = '0;
    bus.write_tag_L2_MEM  = '0;
    bus.write_data_L2_MEM = '0;
    bus.rom_ready         = 1'b0;
    bus.rom_data          = '0;
    bus.ddr_ready         = 1'b0;
    bus.ddr_data          = '0;
  endtask

  task automatic wait_ready(input string nm, input int maxc, output int cyc);
    cyc = 0;
    while (bus.ready_MEM_L2 !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.ready_MEM_L2 !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: got no ready_MEM_L2 within %0d cycles expected a completion", nm, maxc);
    end
  endtask

  // Read-only transaction; dly >= 1 is the cycle count from request seen to backend ready.
  task automatic run_read(input string nm, input tag_t t, input index_t i,
                          input bit to_rom, input int dly, input line_t d);
    int r0, d0, w0;
    r0 = rom_cnt; d0 = ddr_rd_cnt; w0 = ddr_wr_cnt;
    bus.tag_L2_MEM   = t;
    bus.index_L2_MEM = i;
    bus.read_L2_MEM  = 1'b1;
    sb.push_back('{d, exp_err});
    @(negedge clk);
    chk({nm, "_req"}, 64'({bus.rom_read, bus.ddr_read, bus.ddr_write}),
        to_rom ? 64'(3'b100) : 64'(3'b010));
    chk({nm, "_tag"}, 64'(to_rom ? bus.rom_tag : bus.ddr_tag), 64'(t));
    chk({nm, "_index"}, 64'(to_rom ? bus.rom_index : bus.ddr_index), 64'(i));
    bus.tag_L2_MEM   = ~t;
    bus.index_L2_MEM = ~i;
    if (to_rom) begin bus.ddr_ready = 1'b1; bus.ddr_data = ~d; end
    else        begin bus.rom_ready = 1'b1; bus.rom_data = ~d; end
    @(negedge clk);
    bus.ddr_ready = 1'b0;
    bus.rom_ready = 1'b0;
    repeat (dly - 1) @(negedge clk);
    chk({nm, "_held"}, 64'({bus.ready_MEM_L2, bus.rom_read, bus.ddr_read}),
        to_rom ? 64'(3'b010) : 64'(3'b001));
    if (to_rom) begin bus.rom_ready = 1'b1; bus.rom_data = d; end
    else        begin bus.ddr_ready = 1'b1; bus.ddr_data = d; end
    @(negedge clk);
    bus.rom_ready = 1'b0;
    bus.ddr_ready = 1'b0;
    chk({nm, "_latency"}, 64'({bus.ready_MEM_L2, bus.rom_read, bus.ddr_read}), 64'(3'b100));
    chk({nm, "_tag_kept"}, 64'(to_rom ? bus.rom_tag : bus.ddr_tag), 64'(t));
    bus.read_L2_MEM  = 1'b0;
    bus.tag_L2_MEM   = '0;
    bus.index_L2_MEM = '0;
    @(negedge clk);
    chk({nm, "_guard"}, 64'({bus.ready_MEM_L2, bus.busy}), 64'(2'b01));
    @(negedge clk);
    chk({nm, "_idle"}, 64'(bus.busy), 64'(0));
    chk({nm, "_rom_cycles"}, 64'(rom_cnt - r0), to_rom ? 64'(dly + 1) : 64'(0));
    chk({nm, "_ddr_cycles"}, 64'(ddr_rd_cnt - d0), to_rom ? 64'(0) : 64'(dly + 1));
    chk({nm, "_wr_cycles"}, 64'(ddr_wr_cnt - w0), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    line_t w_line, r_line;
    int r0, d0, w0, cyc;
    w_line = {16{32'hDEAD_0006}};
    r_line = {16{32'h4444_0010}};

    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({bus.rom_read, bus.ddr_read, bus.ddr_write, bus.ready_MEM_L2,
                           bus.busy, bus.err}), 64'(0));
    chk_line("reset_data", bus.read_data_MEM_L2, '0);
    chk("reset_tags", 64'({bus.rom_tag, bus.ddr_tag, bus.ddr_write_tag}), 64'(0));
    rstn = 1'b1;
    @(negedge clk);

    run_read("rom_rd", 18'h4, 8'h02, 1'b1, 5, {16{32'hA5A5_A5A5}});
    run_read("ddr_rd", 18'h5, 8'h00, 1'b0, 3, {8{64'h0123_4567_89AB_CDEF}});

    // Writeback to DDR followed by ROM refill.
    r0 = rom_cnt; d0 = ddr_rd_cnt; w0 = ddr_wr_cnt;
    bus.write_L2_MEM      = 1'b1;
    bus.read_L2_MEM       = 1'b1;
    bus.write_tag_L2_MEM  = 18'h6;
    bus.tag_L2_MEM        = 18'h4;
    bus.index_L2_MEM      = 8'h10;
    bus.write_data_L2_MEM = w_line;
    sb.push_back('{r_line, exp_err});
    @(negedge clk);
    chk("wb_req", 64'({bus.rom_read, bus.ddr_read, bus.ddr_write}), 64'(3'b001));
    chk("wb_tag", 64'({bus.ddr_write_tag, bus.ddr_index}), 64'({18'h6, 8'h10}));
    chk_line("wb_data", bus.ddr_write_data, w_line);
    repeat (2) @(negedge clk);
    bus.ddr_ready = 1'b1;
    @(negedge clk);
    bus.ddr_ready = 1'b0;
    chk("wb_to_rom", 64'({bus.rom_read, bus.ddr_read, bus.ddr_write, bus.ready_MEM_L2}),
        64'(4'b1000));
    chk("wb_rom_tag", 64'({bus.rom_tag, bus.rom_index}), 64'({18'h4, 8'h10}));
    @(negedge clk);
    bus.rom_ready = 1'b1;
    bus.rom_data  = r_line;
    @(negedge clk);
    bus.rom_ready = 1'b0;
    chk("wb_ready", 64'(bus.ready_MEM_L2), 64'(1));
    bus.write_L2_MEM = 1'b0;
    bus.read_L2_MEM  = 1'b0;
    repeat (2) @(negedge clk);
    chk("wb_counts", 64'({8'(ddr_wr_cnt - w0), 8'(rom_cnt - r0), 8'(ddr_rd_cnt - d0)}),
        64'({8'd3, 8'd2, 8'd0}));

    // Write to the ROM region: dropped, error flagged, old line returned.
    r0 = rom_cnt; d0 = ddr_rd_cnt; w0 = ddr_wr_cnt;
    exp_err = 1'b1;
    bus.write_L2_MEM      = 1'b1;
    bus.write_tag_L2_MEM  = 18'h4;
    bus.index_L2_MEM      = 8'h05;
    bus.write_data_L2_MEM = w_line;
    sb.push_back('{r_line, 1'b1});
    @(negedge clk);
    chk("romwr_drop", 64'({bus.err, bus.rom_read, bus.ddr_read, bus.ddr_write, bus.ready_MEM_L2}),
        64'(5'b10000));
    @(negedge clk);
    chk("romwr_ready", 64'(bus.ready_MEM_L2), 64'(1));
    bus.write_L2_MEM = 1'b0;
    repeat (2) @(negedge clk);
    chk("romwr_quiet", 64'((rom_cnt - r0) + (ddr_rd_cnt - d0) + (ddr_wr_cnt - w0)), 64'(0));
    chk("romwr_sticky", 64'(bus.err), 64'(1));

    // Reset in the middle of a DDR read.
    bus.tag_L2_MEM   = 18'h7;
    bus.index_L2_MEM = 8'h20;
    bus.read_L2_MEM  = 1'b1;
    sb.push_back('{'0, exp_err});
    repeat (3) @(negedge clk);
    chk("rst_mid_active", 64'(bus.ddr_read), 64'(1));
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({bus.rom_read, bus.ddr_read, bus.ddr_write, bus.ready_MEM_L2,
                             bus.busy, bus.err}), 64'(0));
    chk_line("rst_mid_data", bus.read_data_MEM_L2, '0);
    chk("rst_mid_tag", 64'({bus.ddr_tag, bus.ddr_index}), 64'(0));
    sb.delete();
    bus.read_L2_MEM = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_read("post_rst", 18'h9, 8'h01, 1'b0, 2, {16{32'h0BAD_F00D}});

    // DDR read that never completes.
    d0 = ddr_rd_cnt;
    exp_err = 1'b1;
    bus.tag_L2_MEM   = 18'h5;
    bus.index_L2_MEM = 8'h33;
    bus.read_L2_MEM  = 1'b1;
    sb.push_back('{'0, 1'b1});
    wait_ready("timeout_wait", 5000, cyc);
    chk("timeout_latency", 64'(cyc), 64'(4096));
    chk("timeout_req_cycles", 64'(ddr_rd_cnt - d0), 64'(4095));
    bus.read_L2_MEM = 1'b0;
    repeat (3) @(negedge clk);
    chk("timeout_idle", 64'({bus.busy, bus.ddr_read, bus.err}), 64'(3'b001));

    chk("rd_wr_overlap", 64'(overlap), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l2_mem_router.md
Name: l2_mem_router

Overview:
- Sequences every L2-miss memory transaction and routes it to one of two backends: the instruction ROM (BRAM) or the DDR2 controller.
- Latches the L2 request and decodes the line address against the ROM region. Performs a dirty-line writeback to DDR before the refill read when both are requested. Returns one registered 512-bit line with a single-cycle ready.
- Sits between the cache hierarchy's L2 memory port and the instruction_rom / mig_example_top instances. It replaces the ad hoc L1I/L1D-based steering of memory reads.

Parameters:
- ROM_START_ADDR, 32'h10094, byte address of first ROM instruction
- ROM_END_ADDR, 32'h11FD8, byte address of last ROM instruction (START + (2002-1)*4)
- TNUM, 18, tag width
- INUM, 8, index width
- LINE_W, 512, line width in bits
- TIMEOUT_CYCLES, 4096, backend cycles allowed before abort

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- read_L2_MEM  in  1  L2 refill request, level, held until ready_MEM_L2
- write_L2_MEM  in  1  L2 writeback request, level, held until ready_MEM_L2
- tag_L2_MEM  in  TNUM  refill tag
- index_L2_MEM  in  INUM  index shared by refill and writeback
- write_tag_L2_MEM  in  TNUM  writeback tag
- write_data_L2_MEM  in  LINE_W  writeback line
- read_data_MEM_L2  out  LINE_W  refill line, valid with ready_MEM_L2
- ready_MEM_L2  out  1  one-cycle completion pulse
- rom_read  out  1  ROM read request, level
- rom_tag  out  TNUM  ROM tag
- rom_index  out  INUM  ROM index
- rom_ready  in  1  ROM done pulse
- rom_data  in  LINE_W  ROM line
- ddr_read  out  1  DDR read request, level
- ddr_write  out  1  DDR write request, level
- ddr_tag  out  TNUM  DDR read tag
- ddr_write_tag  out  TNUM  DDR write tag
- ddr_index  out  INUM  DDR index
- ddr_write_data  out  LINE_W  DDR write line
- ddr_ready  in  1  DDR done pulse
- ddr_data  in  LINE_W  DDR line
- busy  out  1  state != IDLE
- err  out  1  sticky error: timeout or ROM-region write

Behaviour:
- Line address is {tag, index} (26 bits = byte address >> 6). It is a ROM line iff ROM_START_ADDR>>6 <= line <= ROM_END_ADDR>>6; with the defaults that is tag 0x4, index 0x02..0x7F. All other line addresses go to DDR.
- Reset (async, rstn=0):
  - state IDLE
  - all request outputs 0; ready_MEM_L2 0; read_data_MEM_L2 0
  - err 0; busy 0; timeout counter 0
  - Reset mid-transaction drops the backend request immediately. The backend sees the request disappear and must tolerate that.
- All outputs are registered.
- States: IDLE, WB, WB_DROP, RD_ROM, RD_DDR, RESP, GUARD.
- IDLE: latch tag, write_tag, index, write_data, and the read and write flags on the first cycle either request is high. Transitions:
  - write with a DDR write_tag -> WB
  - write with a ROM write_tag -> WB_DROP
  - read only -> RD_ROM or RD_DDR by decode
- WB:
  - ddr_write=1 until ddr_ready.
  - On ddr_ready: go to the read decode if the latched read is set, else RESP.
  - ddr_read and ddr_write are never high together.
- WB_DROP (1 cycle): set err; continue as WB would.
- RD_ROM / RD_DDR:
  - Hold the request level.
  - On backend ready: capture data into read_data_MEM_L2, drop the request the next cycle, go to RESP.
- RESP: ready_MEM_L2=1 for exactly one cycle. read_data_MEM_L2 holds its value until the next capture. For a write-only transaction it holds the old value.
- GUARD (1 cycle): ignore requests so that L2 can deassert; then IDLE.
- Latency: request seen at cycle 0 -> backend request at cycle 1 -> backend ready at cycle k -> ready_MEM_L2 at cycle k+1. Minimum read is 3 cycles.
- Timeout:
  - The counter runs in WB/RD_*, clears on state entry and saturates.
  - Reaching TIMEOUT_CYCLES-1 drops the request, sets err, and forces RESP.
  - On a read timeout, read_data_MEM_L2 is 0.
- Backend ready pulses arriving outside the matching state are ignored.
- Input changes while not IDLE are ignored; the latched values are used.

Decomposition:
- Package l2_mem_pkg: state encoding, TNUM/INUM/LINE_W constants, and ROM line-bound constants derived from the address parameters.
- Sub-module l2_mem_region_decode: combinational {tag, index} -> is_rom. It is used for both the refill tag and the write tag.

Test Plan:
- ROM read: read tag 0x4 idx 0x02; rom_ready 5 cycles after rom_read with data 0xA5.. -> rom_read only, ddr_* 0, ready_MEM_L2 one cycle with 0xA5.., err 0.
- DDR read: tag 0x5 idx 0x00 -> ddr_read with tag 0x5, ddr_ready with pattern P -> read_data_MEM_L2=P, rom_read never high.
- Writeback + refill: write tag 0x6 idx 0x10 data W, read tag 0x4 idx 0x10 -> ddr_write with W first; after ddr_ready, rom_read; one ready_MEM_L2 at the end.
- ROM write: write_tag 0x4 idx 0x05 only -> no backend activity, err=1, ready_MEM_L2 pulses once.
- Timeout: DDR read with ddr_ready never asserted -> ddr_read drops after 4095 cycles, ready_MEM_L2 pulses, data 0, err=1.
- Reset mid-read: rstn low during RD_DDR -> all outputs 0 asynchronously; a new request after release completes normally.
